trap_ctrl: RTL

Trap sequencer between the execute/commit point and `csrfile`. It turns ecall, mret and machine-timer interrupts into ordered CSR updates (mepc/mcause/mstatus) and a PC redirect to the fetch unit. It consumes the mtvec, mstatus and mepc values that `csrfile` exports, and it holds the pipeline while a trap is in flight. A local 64-bit machine timer (mtime/mtimecmp) generates the timer interrupt source.

---
 rtl/trap_ctrl_pkg.sv | 49 ++++
 rtl/trap_ctrl_mtimer.sv | 46 ++++
 rtl/trap_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types, CSR constants and mstatus update helpers for trap_ctrl.
package trap_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EV_ECALL = 2'd0,
        EV_MRET  = 2'd1,
        EV_INTR  = 2'd2
    } event_e;

    localparam logic [CPU_WIDTH-1:0] MCAUSE_ECALL_M = CPU_WIDTH'(11);
    localparam logic [CPU_WIDTH-1:0] MCAUSE_MTI =
        {1'b1, {(CPU_WIDTH-4){1'b0}}, 3'd7};

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    function automatic logic [CPU_WIDTH-1:0] trap_mstatus(
        input logic [CPU_WIDTH-1:0] ms
    );
        logic [CPU_WIDTH-1:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [CPU_WIDTH-1:0] mret_mstatus(
        input logic [CPU_WIDTH-1:0] ms
    );
        logic [CPU_WIDTH-1:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_mtimer.sv
// Machine timer: prescaler, 64-bit mtime, mtimecmp and registered mtip.
module mtimer #(
    parameter int TIMER_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmp_wen,
    input  logic [63:0] i_cmp_wdata,
    output logic [63:0] o_mtime,
    output logic        o_mtip
);

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          mtip_q, mtip_d;
    logic          tick;

    always_comb begin
        tick       = (presc_q == PW'(TIMER_DIV - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = i_cmp_wen ? i_cmp_wdata : mtimecmp_q;
        mtip_d     = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            mtip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
        end
    end

    assign o_mtime = mtime_q;
    assign o_mtip  = mtip_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: ecall/mret/timer interrupt to CSR writes and PC redirect.
// Timer interrupt path is built only with TRAP_TIMER_INTR_EN defined.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int TIMER_DIV = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_instr_valid,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic                 i_ecall,
    input  logic                 i_mret,
    input  logic [CPU_WIDTH-1:0] i_mtvec,
    input  logic [CPU_WIDTH-1:0] i_mstatus,
    input  logic [CPU_WIDTH-1:0] i_mepc,
    input  logic                 i_mtimecmp_wen,
    input  logic [63:0]          i_mtimecmp_wdata,
    output logic                 o_mepc_wen,
    output logic [CPU_WIDTH-1:0] o_mepc_wdata,
    output logic                 o_mcause_wen,
    output logic [CPU_WIDTH-1:0] o_mcause_wdata,
    output logic                 o_mstatus_wen,
    output logic [CPU_WIDTH-1:0] o_mstatus_wdata,
    output logic                 o_redirect_valid,
    output logic [CPU_WIDTH-1:0] o_redirect_pc,
    input  logic                 i_redirect_ready,
    output logic                 o_stall,
    output logic [63:0]          o_mtime,
    output logic                 o_mtip
);

    state_e               state_q, state_d;
    event_e               kind_q, kind_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_WIDTH-1:0] tgt_q, tgt_d;
    logic                 take_intr;
    logic                 accept;
    logic                 unused_in;

`ifdef TRAP_TIMER_INTR_EN
    mtimer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_mtimer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmp_wen   (i_mtimecmp_wen),
        .i_cmp_wdata (i_mtimecmp_wdata),
        .o_mtime     (o_mtime),
        .o_mtip      (o_mtip)
    );

    assign take_intr = o_mtip & i_mstatus[MSTATUS_MIE];
    assign unused_in = ^i_mtvec[1:0];
`else
    assign o_mtime   = '0;
    assign o_mtip    = 1'b0;
    assign take_intr = 1'b0;
    assign unused_in = ^{i_mtvec[1:0], i_mtimecmp_wen,
                         i_mtimecmp_wdata, TIMER_DIV[0]};
`endif

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    if (i_mret) begin
                        accept = 1'b1;
                        kind_d = EV_MRET;
                        tgt_d  = i_mepc;
                    end else if (i_ecall) begin
                        accept = 1'b1;
                        kind_d = EV_ECALL;
                        tgt_d  = {i_mtvec[CPU_WIDTH-1:2], 2'b00};
                    end else if (take_intr) begin
                        accept = 1'b1;
                        kind_d = EV_INTR;
                        tgt_d  = {i_mtvec[CPU_WIDTH-1:2], 2'b00};
                    end
                end
                if (accept) begin
                    pc_d    = i_pc;
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP:  state_d = ST_REDIR;
            ST_REDIR: if (i_redirect_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write data is forced to zero whenever its strobe is low.
    always_comb begin
        o_mstatus_wen   = (state_q == ST_TRAP);
        o_mepc_wen      = o_mstatus_wen && (kind_q != EV_MRET);
        o_mcause_wen    = o_mepc_wen;
        o_mepc_wdata    = o_mepc_wen ? pc_q : '0;
        o_mcause_wdata  = '0;
        o_mstatus_wdata = '0;
        if (o_mcause_wen)
            o_mcause_wdata = (kind_q == EV_INTR) ? MCAUSE_MTI
                                                 : MCAUSE_ECALL_M;
        if (o_mstatus_wen)
            o_mstatus_wdata = (kind_q == EV_MRET) ? mret_mstatus(i_mstatus)
                                                  : trap_mstatus(i_mstatus);
        o_redirect_valid = (state_q == ST_REDIR);
        o_redirect_pc    = o_redirect_valid ? tgt_q : '0;
        o_stall          = accept || (state_q != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= EV_ECALL;
            pc_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule
